// File: rtl/note_player.sv
// -----------------------------------------------------------------------------
// note_player
//
// Plays one note per melody-library entry on a square-wave speaker pin. Each
// note is timed in duration units of UNIT_CYCLES clocks, ends with a silent
// articulation gap of GAP_CYCLES clocks, and is followed by a one-cycle
// next_note pulse that advances the library. The song loops because the
// library wraps its own index.
//
// Ports:
//   clk        in   system clock
//   clr_n      in   asynchronous active-low reset
//   play       in   level: 1 = run the song, 0 = stop and silence
//   duration   in   3-bit duration code from the library (0 = fetch/wrap)
//   ticks      in   tone half-period in clk cycles (0 = rest)
//   next_note  out  one-cycle pulse that advances the library
//   speaker    out  square-wave audio output
//   busy       out  high whenever the player is not idle
// -----------------------------------------------------------------------------
module note_player #(
  parameter int unsigned TICKBITS    = 18,
  parameter int unsigned UNIT_CYCLES = 2083333,
  parameter int unsigned UNITBITS    = 22,
  parameter int unsigned GAP_CYCLES  = 200000
) (
  input  logic                clk,
  input  logic                clr_n,
  input  logic                play,
  input  logic [2:0]          duration,
  input  logic [TICKBITS-1:0] ticks,
  output logic                next_note,
  output logic                speaker,
  output logic                busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_TONE,
    S_GAP,
    S_ADVANCE,
    S_WAIT
  } state_e;

  localparam logic [UNITBITS-1:0] UNIT_LAST = UNITBITS'(UNIT_CYCLES - 1);
  // Last unit-counter value of the audible part of the final unit.
  localparam logic [UNITBITS-1:0] TONE_LAST = UNITBITS'(UNIT_CYCLES - GAP_CYCLES - 1);
  localparam bit                  HAS_GAP   = (GAP_CYCLES != 0);

  state_e              state_q,      state_d;
  logic [TICKBITS-1:0] ticks_q,      ticks_d;
  logic [TICKBITS-1:0] tone_cnt_q,   tone_cnt_d;
  logic [UNITBITS-1:0] unit_cnt_q,   unit_cnt_d;
  logic [4:0]          units_left_q, units_left_d;
  logic                speaker_q,    speaker_d;
  logic                next_note_q,  next_note_d;
  logic                busy_q,       busy_d;

  logic unit_wrap;

  // Duration code to unit count; codes 6/7 are invalid and play one unit.
  function automatic logic [4:0] units_of(input logic [2:0] code);
    case (code)
      3'd1:    units_of = 5'd24;
      3'd2:    units_of = 5'd12;
      3'd3:    units_of = 5'd8;
      3'd4:    units_of = 5'd6;
      3'd5:    units_of = 5'd4;
      default: units_of = 5'd1;
    endcase
  endfunction

  assign unit_wrap = (unit_cnt_q == UNIT_LAST);

  // NOTE: every signal written here gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    state_d      = state_q;
    ticks_d      = ticks_q;
    tone_cnt_d   = tone_cnt_q;
    unit_cnt_d   = unit_cnt_q;
    units_left_d = units_left_q;
    speaker_d    = 1'b0;

    case (state_q)
      S_IDLE: state_d = S_LOAD;

      S_LOAD: begin
        // Code 0 means the library is wrapping: resample next cycle.
        if (duration != 3'd0) begin
          units_left_d = units_of(duration);
          ticks_d      = (duration >= 3'd6) ? '0 : ticks;
          unit_cnt_d   = '0;
          tone_cnt_d   = '0;
          state_d      = S_TONE;
        end
      end

      S_TONE: begin
        if (ticks_q == '0) begin
          tone_cnt_d = '0;
        end else if (tone_cnt_q == ticks_q - TICKBITS'(1)) begin
          tone_cnt_d = '0;
          speaker_d  = ~speaker_q;
        end else begin
          tone_cnt_d = tone_cnt_q + TICKBITS'(1);
          speaker_d  = speaker_q;
        end

        unit_cnt_d = unit_wrap ? '0 : unit_cnt_q + UNITBITS'(1);
        if (unit_wrap) units_left_d = units_left_q - 5'd1;

        if (units_left_q == 5'd1 && unit_cnt_q == TONE_LAST) begin
          speaker_d = 1'b0;
          state_d   = HAS_GAP ? S_GAP : S_ADVANCE;
        end
      end

      // The unit counter keeps running so the gap closes out the last unit.
      S_GAP: begin
        unit_cnt_d = unit_wrap ? '0 : unit_cnt_q + UNITBITS'(1);
        if (unit_wrap) begin
          units_left_d = units_left_q - 5'd1;
          state_d      = S_ADVANCE;
        end
      end

      S_ADVANCE: state_d = S_WAIT;

      // Gives the library a cycle to register its new index before LOAD.
      S_WAIT:    state_d = S_LOAD;

      default:   state_d = S_IDLE;
    endcase

    // Stopping never advances the library, so the next play replays the note.
    if (!play) begin
      state_d   = S_IDLE;
      speaker_d = 1'b0;
    end

    next_note_d = (state_d == S_ADVANCE);
    busy_d      = (state_d != S_IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the values from before this edge.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q      <= S_IDLE;
      ticks_q      <= '0;
      tone_cnt_q   <= '0;
      unit_cnt_q   <= '0;
      units_left_q <= '0;
      speaker_q    <= 1'b0;
      next_note_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      ticks_q      <= ticks_d;
      tone_cnt_q   <= tone_cnt_d;
      unit_cnt_q   <= unit_cnt_d;
      units_left_q <= units_left_d;
      speaker_q    <= speaker_d;
      next_note_q  <= next_note_d;
      busy_q       <= busy_d;
    end
  end

  assign next_note = next_note_q;
  assign speaker   = speaker_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_note_player.sv
// -----------------------------------------------------------------------------
// tb_note_player
//
// Drives note_player from a small stub melody library and compares every
// cycle's {next_note, speaker, busy} against a reference model that describes
// each note as a timeline of offsets from its LOAD cycle:
//   offset 0            LOAD
//   1 .. N-GAP          tone (speaker toggles every T cycles, T = 0 is a rest)
//   N-GAP+1 .. N        silent gap
//   N+1                 next_note pulse
//   N+2                 library settles; offset N+3 is the next LOAD
// with N = units * UNIT_CYCLES.
// -----------------------------------------------------------------------------
module tb_note_player;

  localparam int UC = 10;
  localparam int GC = 2;
  localparam int TB = 8;
  localparam int UB = 4;

  logic          clk;
  logic          clr_n;
  logic          play;
  logic          lib_rst;
  logic [2:0]    duration;
  logic [TB-1:0] ticks;
  logic          next_note;
  logic          speaker;
  logic          busy;

  // Stub library: entry index advances on each next_note and wraps.
  logic [2:0]    lib_d [8];
  logic [TB-1:0] lib_t [8];
  int            lib_len;
  int            lib_idx;

  int n_checks;
  int n_errors;
  int cyc;
  int pulse_cnt;

  // Reference model: mode 0 idle, 1 in LOAD, 2 inside a note at offset m_off.
  int m_mode;
  int m_off;
  int m_units;
  int m_t;
  int m_idx;

  note_player #(
    .TICKBITS   (TB),
    .UNIT_CYCLES(UC),
    .UNITBITS   (UB),
    .GAP_CYCLES (GC)
  ) dut (
    .clk      (clk),
    .clr_n    (clr_n),
    .play     (play),
    .duration (duration),
    .ticks    (ticks),
    .next_note(next_note),
    .speaker  (speaker),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign duration = lib_d[lib_idx];
  assign ticks    = lib_t[lib_idx];

  always @(posedge clk) begin
    if (lib_rst)        lib_idx <= 0;
    else if (next_note) lib_idx <= (lib_idx + 1 >= lib_len) ? 0 : lib_idx + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int note_units(input int code);
    case (code)
      1:       return 24;
      2:       return 12;
      3:       return 8;
      4:       return 6;
      5:       return 4;
      6, 7:    return 1;
      default: return 0;
    endcase
  endfunction

  // Advance the model across one rising edge, using the inputs held before it.
  task automatic model_edge();
    int code;
    if (m_mode == 2 && m_off == m_units * UC + 1) m_idx = (m_idx + 1) % lib_len;
    if (!play) begin
      m_mode = 0;
    end else if (m_mode == 0) begin
      m_mode = 1;
    end else if (m_mode == 1) begin
      code = int'(lib_d[m_idx]);
      if (code != 0) begin
        m_units = note_units(code);
        m_t     = (code >= 6) ? 0 : int'(lib_t[m_idx]);
        m_off   = 1;
        m_mode  = 2;
      end
    end else begin
      m_off++;
      if (m_off == m_units * UC + 3) m_mode = 1;
    end
  endtask

  // Expected {next_note, speaker, busy} for the current model position.
  function automatic logic [2:0] model_out();
    int  n;
    logic spk;
    logic nxt;
    if (m_mode == 0) return 3'b000;
    if (m_mode == 1) return 3'b001;
    n   = m_units * UC;
    nxt = (m_off == n + 1);
    spk = 1'b0;
    if (m_off >= 1 && m_off <= n - GC && m_t > 0) spk = (((m_off - 1) / m_t) % 2) == 1;
    return {nxt, spk, 1'b1};
  endfunction

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    cyc++;
    if (next_note === 1'b1) pulse_cnt++;
    check($sformatf("cycle%0d", cyc), 32'({next_note, speaker, busy}), 32'(model_out()));
  endtask

  // Ticks until a next_note pulse is seen; n = -1 if none within the limit.
  task automatic wait_pulse(input int limit, output int n);
    n = -1;
    for (int i = 1; i <= limit; i++) begin
      tick();
      if (next_note === 1'b1) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic lib_restart(input int len);
    lib_len = len;
    lib_rst = 1'b1;
    tick();
    lib_rst = 1'b0;
    m_idx   = 0;
  endtask

  initial begin
    int n;

    n_checks  = 0;
    n_errors  = 0;
    cyc       = 0;
    pulse_cnt = 0;
    m_mode    = 0;
    m_off     = 0;
    m_units   = 0;
    m_t       = 0;
    m_idx     = 0;
    lib_len   = 1;
    lib_rst   = 1'b1;
    play      = 1'b0;
    clr_n     = 1'b0;
    for (int i = 0; i < 8; i++) begin
      lib_d[i] = 3'd0;
      lib_t[i] = '0;
    end

    // Reset and idle
    repeat (3) @(negedge clk);
    check("rst_speaker", 32'(speaker),   32'd0);
    check("rst_busy",    32'(busy),      32'd0);
    check("rst_next",    32'(next_note), 32'd0);
    clr_n   = 1'b1;
    lib_rst = 1'b0;
    repeat (1000) tick();
    check("idle_pulses", 32'(pulse_cnt), 32'd0);

    // Single eighth note, then its repeat
    lib_d[0] = 3'd2; lib_t[0] = TB'(5);
    lib_restart(1);
    play = 1'b1;
    wait_pulse(400, n);
    check("eighth_first_pulse", 32'(n), 32'(note_units(2) * UC + 2));
    wait_pulse(400, n);
    check("eighth_period", 32'(n), 32'(note_units(2) * UC + 3));
    play = 1'b0;
    repeat (2) tick();

    // Rest note followed by a fetch code that holds the player in LOAD
    lib_d[0] = 3'd4; lib_t[0] = TB'(0);
    lib_d[1] = 3'd0; lib_t[1] = TB'(9);
    lib_restart(2);
    play = 1'b1;
    wait_pulse(400, n);
    check("rest_pulse", 32'(n), 32'(note_units(4) * UC + 2));
    pulse_cnt = 0;
    repeat (100) tick();
    check("fetch_pulses", 32'(pulse_cnt), 32'd0);
    check("fetch_busy",   32'(busy),      32'd1);
    play = 1'b0;
    repeat (2) tick();

    // Sequence handoff with library wrap
    lib_d[0] = 3'd1; lib_t[0] = TB'(3);
    lib_d[1] = 3'd5; lib_t[1] = TB'(7);
    lib_d[2] = 3'd3; lib_t[2] = TB'(0);
    lib_restart(3);
    play = 1'b1;
    wait_pulse(400, n);
    check("seq_first_pulse", 32'(n), 32'(note_units(1) * UC + 2));
    for (int i = 1; i <= 4; i++) begin
      wait_pulse(400, n);
      check($sformatf("seq_gap%0d", i), 32'(n), 32'(note_units(int'(lib_d[i % 3])) * UC + 3));
    end
    play = 1'b0;
    repeat (2) tick();

    // Pause mid-note and replay the same note from its start
    lib_d[0] = 3'd1; lib_t[0] = TB'(9);
    lib_d[1] = 3'd2; lib_t[1] = TB'(4);
    lib_restart(2);
    play = 1'b1;
    repeat (50) tick();
    play = 1'b0;
    tick();
    check("pause_busy",    32'(busy),    32'd0);
    check("pause_speaker", 32'(speaker), 32'd0);
    pulse_cnt = 0;
    repeat (20) tick();
    check("pause_pulses", 32'(pulse_cnt), 32'd0);
    play = 1'b1;
    wait_pulse(400, n);
    check("replay_pulse", 32'(n), 32'(note_units(1) * UC + 2));
    wait_pulse(400, n);
    check("replay_next_note", 32'(n), 32'(note_units(2) * UC + 3));
    play = 1'b0;
    repeat (2) tick();

    // Invalid duration code plays one silent unit
    lib_d[0] = 3'd7; lib_t[0] = TB'(55);
    lib_d[1] = 3'd2; lib_t[1] = TB'(4);
    lib_restart(2);
    play = 1'b1;
    wait_pulse(400, n);
    check("invalid_pulse", 32'(n), 32'(UC + 2));
    wait_pulse(400, n);
    check("after_invalid", 32'(n), 32'(note_units(2) * UC + 3));
    play = 1'b0;
    repeat (2) tick();

    // Asynchronous reset between clock edges while the speaker is high
    lib_d[0] = 3'd1; lib_t[0] = TB'(3);
    lib_restart(1);
    play = 1'b1;
    repeat (5) tick();
    check("pre_rst_speaker", 32'(speaker), 32'd1);
    #2;
    clr_n = 1'b0;
    #1;
    check("async_rst_speaker", 32'(speaker),   32'd0);
    check("async_rst_busy",    32'(busy),      32'd0);
    check("async_rst_next",    32'(next_note), 32'd0);
    play = 1'b0;
    @(posedge clk);
    @(negedge clk);
    m_mode = 0;
    check("held_rst_busy", 32'(busy), 32'd0);
    clr_n = 1'b1;
    repeat (3) tick();

    // Randomized library contents with random stop/start of play
    for (int i = 0; i < 6; i++) begin
      lib_d[i] = 3'($urandom_range(1, 7));
      lib_t[i] = TB'($urandom_range(0, 12));
    end
    lib_restart(6);
    pulse_cnt = 0;
    play = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      tick();
      if (play && $urandom_range(0, 299) == 0)       play = 1'b0;
      else if (!play && $urandom_range(0, 3) == 0)   play = 1'b1;
    end
    check("rand_pulses_seen", 32'(pulse_cnt > 0), 32'd1);
    play = 1'b0;
    repeat (2) tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
